// File: rtl/zbuf_pkg.sv
// rtl/zbuf_pkg.sv - shared constants, FSM encoding and address helper for the z-block fetcher
package zbuf_pkg;

    localparam int BLK_ID_W       = 15;
    localparam int WORDS_PER_BLK  = 8;
    localparam int Z_WORD_W       = 32;
    localparam int BLK_BYTES_LOG2 = 5;
    localparam int WORD_IDX_W     = $clog2(WORDS_PER_BLK);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_BLK - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_COLLECT = 3'd2,
        ST_STREAM  = 3'd3,
        ST_GAP     = 3'd4
    } fetch_state_t;

    // Byte offset of a z-block inside the z-buffer region: 32 bytes per block.
    function automatic logic [BLK_ID_W+BLK_BYTES_LOG2-1:0] blk_byte_offset(
        input logic [BLK_ID_W-1:0] id
    );
        return {id, {BLK_BYTES_LOG2{1'b0}}};
    endfunction

endpackage

// File: rtl/zbuf_fetch_fifo.sv
// rtl/zbuf_fetch_fifo.sv - synchronous FIFO of pending block IDs with all entries exposed
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  enqueue one ID (ignored when full)
//   pop              dequeue the head (ignored when empty)
//   head             oldest entry
//   empty, full      occupancy flags (reflect state before this cycle's push/pop)
//   entries, valid   every storage slot and its occupancy bit, for duplicate matching
module zbuf_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      empty,
    output logic                      full,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign head    = entries[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            entries <= '0;
            valid   <= '0;
        end else begin
            // Clear before set: a push can never target the slot being popped
            // (push is blocked when full), but this ordering keeps that safe.
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zbuf_block_fetch.sv
// rtl/zbuf_block_fetch.sv - fetches 8-word z-blocks from RAM and streams them to the block cache
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   fetch_id, fetch_req, fetch_ack miss request in; ack is combinational (enqueued or duplicate)
//   mem_rd_addr/req/gnt            RAM burst request, held until granted
//   mem_rd_data/vld                RAM read beats, 8 per burst, gaps allowed
//   block_wr_addr/data/new/en      cache write port, 8 contiguous words, new marks word 0
//   busy                           work in flight or queued
//   err_spur_beat                  sticky flag for a read beat outside COLLECT
module zbuf_block_fetch
    import zbuf_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] ZBUF_BASE  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BLK_ID_W-1:0]  fetch_id,
    input  logic                 fetch_req,
    output logic                 fetch_ack,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    output logic                 mem_rd_req,
    input  logic                 mem_rd_gnt,
    input  logic [Z_WORD_W-1:0]  mem_rd_data,
    input  logic                 mem_rd_vld,
    output logic [BLK_ID_W-1:0]  block_wr_addr,
    output logic [Z_WORD_W-1:0]  block_wr_data,
    output logic                 block_wr_new,
    output logic                 block_wr_en,
    output logic                 busy,
    output logic                 err_spur_beat
);

    fetch_state_t              state;
    logic [BLK_ID_W-1:0]       cur_id;
    logic [WORD_IDX_W-1:0]     beat_cnt;
    logic [WORD_IDX_W-1:0]     s_cnt;
    logic [Z_WORD_W-1:0]       linebuf [WORDS_PER_BLK];

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [BLK_ID_W-1:0]       fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [FIFO_DEPTH-1:0][BLK_ID_W-1:0] fifo_entries;
    logic [FIFO_DEPTH-1:0]     fifo_valid;

    logic                      in_flight;
    logic                      dup;

    zbuf_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BLK_ID_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fetch_id),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .entries   (fifo_entries),
        .valid     (fifo_valid)
    );

    // The block being fetched counts as pending until its stream ends; in GAP
    // the cache already holds it, so a re-request there is a genuine new miss.
    assign in_flight = (state == ST_REQ) || (state == ST_COLLECT) || (state == ST_STREAM);

    always_comb begin
        dup = in_flight && (fetch_id == cur_id);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i] == fetch_id)) begin
                dup = 1'b1;
            end
        end
    end

    // Full is the pre-pop value, so a request is never passed through a full
    // queue in the same cycle the head leaves.
    assign fetch_ack = fetch_req & (dup | ~fifo_full);
    assign fifo_push = fetch_req & ~dup & ~fifo_full;
    assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
    assign busy      = (state != ST_IDLE) | ~fifo_empty;

    // Line buffer has no reset: its contents are only read after a full set
    // of 8 beats has been written for the current block.
    always_ff @(posedge clk) begin
        if ((state == ST_COLLECT) && mem_rd_vld) begin
            linebuf[beat_cnt] <= mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_id        <= '0;
            beat_cnt      <= '0;
            s_cnt         <= '0;
            mem_rd_addr   <= '0;
            mem_rd_req    <= 1'b0;
            block_wr_addr <= '0;
            block_wr_data <= '0;
            block_wr_new  <= 1'b0;
            block_wr_en   <= 1'b0;
            err_spur_beat <= 1'b0;
        end else begin
            if (mem_rd_vld && (state != ST_COLLECT)) begin
                err_spur_beat <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_id      <= fifo_head;
                        mem_rd_addr <= ZBUF_BASE + ADDR_W'(blk_byte_offset(fifo_head));
                        mem_rd_req  <= 1'b1;
                        state       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (mem_rd_vld) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_WORD) begin
                            // Word 0 is already in the line buffer; present it now
                            // so the cache sees the first word one cycle after the 8th beat.
                            s_cnt         <= '0;
                            block_wr_en   <= 1'b1;
                            block_wr_new  <= 1'b1;
                            block_wr_addr <= cur_id;
                            block_wr_data <= linebuf[0];
                            state         <= ST_STREAM;
                        end
                    end
                end

                ST_STREAM: begin
                    block_wr_new <= 1'b0;
                    if (s_cnt == LAST_WORD) begin
                        block_wr_en <= 1'b0;
                        state       <= ST_GAP;
                    end else begin
                        s_cnt         <= s_cnt + 1'b1;
                        block_wr_data <= linebuf[s_cnt + 1'b1];
                    end
                end

                ST_GAP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
